// File: rtl/controle_banco_registro_pkg.sv
// Shared definitions for the register-bank access sequencer: FSM states and default widths.
package controle_banco_registro_pkg;

  localparam int unsigned BITS_PALAVRA_PADRAO  = 32;
  localparam int unsigned END_REGISTROS_PADRAO = 4;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESSO  = 2'd1,
    CAPTURA = 2'd2
  } estado_t;

endpackage

// File: rtl/controle_banco_registro_arbitro_rr2.sv
// Two-input picker: round-robin by preferred-port pointer, or fixed priority to port 0.
module arbitro_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       fixa,
  output logic [1:0] vencedor
);

  // ptr names the port preferred on a tie
  always_comb begin
    vencedor = '0;
    case (req)
      2'b01:   vencedor = 2'b01;
      2'b10:   vencedor = 2'b10;
      2'b11:   vencedor = (fixa || !ptr) ? 2'b01 : 2'b10;
      default: vencedor = '0;
    endcase
  end

endmodule

// File: rtl/controle_banco_registro.sv
// Arbiter/sequencer sharing the single-write, dual-read register bank between
// execute writeback (port 0) and the load/debug unit (port 1).
module controle_banco_registro
  import controle_banco_registro_pkg::*;
#(
  parameter int unsigned BITS_PALAVRA    = BITS_PALAVRA_PADRAO,
  parameter int unsigned END_REGISTROS   = END_REGISTROS_PADRAO,
  parameter int unsigned PRIORIDADE_FIXA = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [END_REGISTROS-1:0] addr_a0,
  input  logic [END_REGISTROS-1:0] addr_a1,
  input  logic [END_REGISTROS-1:0] addr_b0,
  input  logic [END_REGISTROS-1:0] addr_b1,
  input  logic [BITS_PALAVRA-1:0]  wdata0,
  input  logic [BITS_PALAVRA-1:0]  wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [BITS_PALAVRA-1:0]  rdata_a,
  output logic [BITS_PALAVRA-1:0]  rdata_b,
  output logic                     bank_hab,
  output logic [END_REGISTROS-1:0] bank_addr_a,
  output logic [END_REGISTROS-1:0] bank_addr_b,
  output logic [BITS_PALAVRA-1:0]  bank_e,
  input  logic [BITS_PALAVRA-1:0]  bank_a,
  input  logic [BITS_PALAVRA-1:0]  bank_b
);

  estado_t    estado, proximo;
  logic       ptr;
  logic       porta;
  logic       we_lat;
  logic [1:0] pedidos;
  logic [1:0] elegiveis;
  logic [1:0] vencedor;
  logic       carga;

  assign pedidos = {req1, req0};

  // In CAPTURA the port just served is masked, so a held req only counts again later
  always_comb begin
    elegiveis = '0;
    proximo   = estado;
    case (estado)
      OCIOSO: begin
        elegiveis = pedidos;
        if (|elegiveis) proximo = ACESSO;
      end
      ACESSO: proximo = CAPTURA;
      CAPTURA: begin
        elegiveis = pedidos & ~(porta ? 2'b10 : 2'b01);
        proximo   = (|elegiveis) ? ACESSO : OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  assign carga = (proximo == ACESSO);

  arbitro_rr2 u_arbitro (
    .req      (elegiveis),
    .ptr      (ptr),
    .fixa     (PRIORIDADE_FIXA != 0),
    .vencedor (vencedor)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      ptr         <= 1'b0;
      porta       <= 1'b0;
      we_lat      <= 1'b0;
      bank_addr_a <= '0;
      bank_addr_b <= '0;
      bank_e      <= '0;
    end else begin
      estado <= proximo;
      if (carga) begin
        porta <= vencedor[1];
        ptr   <= vencedor[0];
        if (vencedor[1]) begin
          we_lat      <= we1;
          bank_addr_a <= addr_a1;
          bank_addr_b <= addr_b1;
          bank_e      <= wdata1;
        end else begin
          we_lat      <= we0;
          bank_addr_a <= addr_a0;
          bank_addr_b <= addr_b0;
          bank_e      <= wdata0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= (estado == CAPTURA) && !porta;
      rvalid1 <= (estado == CAPTURA) && porta;
      if (estado == CAPTURA) begin
        rdata_a <= bank_a;
        rdata_b <= bank_b;
      end
    end
  end

  // Decoded from state so the write enable falls the instant reset asserts
  assign gnt0     = (estado == ACESSO) && !porta;
  assign gnt1     = (estado == ACESSO) && porta;
  assign bank_hab = (estado == ACESSO) && we_lat;

endmodule
